// File: rtl/barrel_shift_ctrl.sv
// Streaming rotate engine: a DEPTH-entry command FIFO feeding a combinational
// rotator, with the result held in a valid/ready output register.
module barrel_shift_ctrl #(
    parameter int BIT   = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [BIT-1:0]             i_data,
    input  logic                       i_sel_left,
    input  logic [$clog2(BIT)-1:0]     i_shifter,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [BIT-1:0]             o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int SW = $clog2(BIT);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW:0]   BIT_W    = (SW + 1)'(BIT);

    logic [BIT-1:0] r_mem_data [DEPTH];
    logic           r_mem_left [DEPTH];
    logic [SW-1:0]  r_mem_amt  [DEPTH];

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_valid;
    logic [BIT-1:0] r_data;

    logic           w_push;
    logic           w_load;
    logic [BIT-1:0] w_head;
    logic           w_left;
    logic [SW-1:0]  w_amt;
    logic [SW:0]    w_inv;
    logic [BIT-1:0] w_rot_l;
    logic [BIT-1:0] w_rot_r;
    logic [BIT-1:0] w_rot;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_ready = !o_full;
    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Full refuses pushes even when a pop happens in the same cycle.
    assign w_push = i_valid && o_ready;
    assign w_load = !o_empty && (!r_valid || i_ready);

    assign w_head = r_mem_data[r_rd_ptr];
    assign w_left = r_mem_left[r_rd_ptr];
    assign w_amt  = r_mem_amt[r_rd_ptr];

    // Shifting by BIT (k = 0) yields zero, so the OR leaves the data unchanged.
    assign w_inv   = BIT_W - {1'b0, w_amt};
    assign w_rot_l = (w_head << w_amt) | (w_head >> w_inv);
    assign w_rot_r = (w_head >> w_amt) | (w_head << w_inv);
    assign w_rot   = w_left ? w_rot_l : w_rot_r;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= i_data;
            r_mem_left[r_wr_ptr] <= i_sel_left;
            r_mem_amt[r_wr_ptr]  <= i_shifter;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            if (w_load) begin
                r_data   <= w_rot;
                r_valid  <= 1'b1;
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// Bench for barrel_shift_ctrl: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the FIFO and output stage.
module tb_barrel_shift_ctrl;

    localparam int BIT   = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 3;
    localparam int CW    = 3;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic [BIT-1:0] i_data = '0;
    logic           i_sel_left = 1'b0;
    logic [SW-1:0]  i_shifter = '0;
    logic           o_valid;
    logic           i_ready = 1'b0;
    logic [BIT-1:0] o_data;
    logic [CW-1:0]  o_count;
    logic           o_full;
    logic           o_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BIT-1:0] m_q[$];
    logic           m_ov = 1'b0;
    logic [BIT-1:0] m_od = '0;

    barrel_shift_ctrl #(.BIT(BIT), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_sel_left (i_sel_left),
        .i_shifter  (i_shifter),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BIT-1:0] rot_ref(input logic [BIT-1:0] d, input logic left, input int k);
        logic [BIT-1:0] r;
        for (int i = 0; i < BIT; i++) begin
            if (left) r[i] = d[(i - k + BIT) % BIT];
            else      r[i] = d[(i + k) % BIT];
        end
        return r;
    endfunction

    task automatic cycle();
        bit push, load;
        logic [BIT-1:0] res;
        push = i_valid && (m_q.size() < DEPTH);
        load = (m_q.size() != 0) && (!m_ov || i_ready);
        res  = rot_ref(i_data, i_sel_left, int'(i_shifter));
        @(posedge i_clk);
        if (i_rst) begin
            m_q.delete();
            m_ov = 1'b0;
            m_od = '0;
        end else begin
            if (load) begin
                m_od = m_q.pop_front();
                m_ov = 1'b1;
            end else if (m_ov && i_ready) begin
                m_ov = 1'b0;
            end
            if (push) m_q.push_back(res);
        end
        #1;
        chk("valid", o_valid, m_ov);
        chk("data",  o_data,  m_od);
        chk("count", o_count, m_q.size());
        chk("ready", o_ready, m_q.size() < DEPTH);
        chk("full",  o_full,  m_q.size() == DEPTH);
        chk("empty", o_empty, m_q.size() == 0);
    endtask

    task automatic drive(input logic v, input logic [BIT-1:0] d, input logic l, input logic [SW-1:0] k);
        i_valid    = v;
        i_data     = d;
        i_sel_left = l;
        i_shifter  = k;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 8'h00, 1'b0, 3'd0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [BIT-1:0] drain_exp [5] = '{8'h43, 8'h65, 8'h78, 8'hD4, 8'hD4};

    initial begin
        i_rst = 1'b1;
        cycle();
        cycle();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_count", o_count, 3'd0);
        i_rst = 1'b0;

        // Rotate the same data both ways
        i_ready = 1'b1;
        drive(1'b1, 8'h81, 1'b1, 3'd1); cycle();
        chk("t1_latency", o_valid, 1'b0);
        drive(1'b1, 8'h81, 1'b0, 3'd1); cycle();
        chk("t1_left", o_data, 8'h03);
        idle(1);
        chk("t1_right", o_data, 8'hC0);
        idle(2);

        // Zero and maximal rotate amounts
        drive(1'b1, 8'hA5, 1'b1, 3'd0); cycle();
        drive(1'b1, 8'hA5, 1'b0, 3'd0); cycle();
        chk("t2_l0", o_data, 8'hA5);
        drive(1'b1, 8'h01, 1'b1, 3'd7); cycle();
        chk("t2_r0", o_data, 8'hA5);
        idle(1);
        chk("t2_l7", o_data, 8'h80);
        idle(2);

        // Fill under backpressure
        i_ready = 1'b0;
        drive(1'b1, 8'h12, 1'b1, 3'd1); cycle();
        drive(1'b1, 8'h34, 1'b0, 3'd4); cycle();
        drive(1'b1, 8'h56, 1'b1, 3'd4); cycle();
        drive(1'b1, 8'h78, 1'b0, 3'd0); cycle();
        drive(1'b1, 8'h9A, 1'b1, 3'd3); cycle();
        chk("t3_count", o_count, 3'd4);
        chk("t3_full",  o_full,  1'b1);
        chk("t3_ready", o_ready, 1'b0);
        drive(1'b1, 8'hFF, 1'b1, 3'd2);
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_held_off", o_count, 3'd4);

        // Backpressure stability and ordered drain
        drive(1'b0, 8'h00, 1'b0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_stable", o_data, 8'h24);
        end
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_drain", o_data, drain_exp[i]);
        end
        chk("t4_empty", o_empty, 1'b1);
        chk("t4_valid", o_valid, 1'b0);

        // Streaming at full rate
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, BIT'($urandom), i[0], SW'(i % 8));
            cycle();
            chk("t5_count_le1", o_count <= 3'd1, 1'b1);
            if (i > 0) chk("t5_no_gap", o_valid, 1'b1);
        end
        idle(3);

        // Reset mid-operation wins over a concurrent push
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, BIT'($urandom), 1'b1, SW'($urandom_range(0, 7)));
            cycle();
        end
        chk("t6_pre_count", o_count, 3'd3);
        i_rst = 1'b1;
        drive(1'b1, 8'h11, 1'b1, 3'd1);
        cycle();
        i_rst = 1'b0;
        chk("t6_valid", o_valid, 1'b0);
        chk("t6_data",  o_data,  8'h00);
        chk("t6_count", o_count, 3'd0);
        chk("t6_ready", o_ready, 1'b1);
        i_ready = 1'b1;
        drive(1'b1, 8'h3C, 1'b1, 3'd2); cycle();
        idle(1);
        chk("t6_new", o_data, 8'hF0);
        idle(1);
        chk("t6_only_new", o_valid, 1'b0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            i_rst   = ($urandom_range(0, 60) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, BIT'($urandom), 1'($urandom), SW'($urandom));
            cycle();
        end
        i_rst = 1'b0;
        i_ready = 1'b1;
        idle(8);
        chk("end_empty", o_empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
